// File: rtl/uart_wrapper.sv
// ECG board UART link: 8N1 receiver, response generator and 8N1 transmitter.
// One command byte N is answered with RESP_LEN bytes N, N+1, ... (mod 256).
module uart_wrapper #(
  parameter int unsigned CLK_FREQ_HZ  = 12_500_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
  parameter int unsigned RESP_LEN     = 32
) (
  input  logic sysclk,
  input  logic resetn,
  input  logic uart_txd_in,
  output logic uart_rxd_out
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [5:0] K_END = 6'(RESP_LEN);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    GEN_IDLE, GEN_SEND, GEN_WAIT
  } gen_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;

  gen_state_e       gen_state_q, gen_state_d;
  logic [7:0]       seed_q, seed_d;
  logic [5:0]       k_q, k_d;
  logic [5:0]       k_inc;
  logic             tx_start;
  logic [7:0]       tx_data;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;
  logic             tx_done;

  assign uart_rxd_out = txd_q;

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      gen_state_q <= GEN_IDLE;
      seed_q      <= '0;
      k_q         <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
    end else begin
      rx_meta_q   <= uart_txd_in;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      gen_state_q <= gen_state_d;
      seed_q      <= seed_d;
      k_q         <= k_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:
        if (rx_prev_q && !rx_sync_q)
          rx_state_d = RX_START;
      RX_START:
        if (rx_cnt_q == HALF_LAST)
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_cnt_q == BIT_LAST && rx_bit_q == 3'd7)
          rx_state_d = RX_STOP;
      RX_STOP:
        if (rx_cnt_q == BIT_LAST)
          rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Sampling points fall mid-bit once START has consumed half a bit.
  always_comb begin
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
      end
      RX_START:
        if (rx_cnt_q == HALF_LAST)
          rx_cnt_d = '0;
      RX_DATA:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        end
      RX_STOP:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_sync_q;
        end
      default: rx_cnt_d = '0;
    endcase
  end

  assign k_inc = k_q + 6'd1;

  always_comb begin
    gen_state_d = gen_state_q;
    unique case (gen_state_q)
      GEN_IDLE:
        if (rx_valid_q)
          gen_state_d = GEN_SEND;
      GEN_SEND:
        gen_state_d = GEN_WAIT;
      GEN_WAIT:
        if (tx_done)
          gen_state_d = (k_inc == K_END) ? GEN_IDLE : GEN_SEND;
      default: gen_state_d = GEN_IDLE;
    endcase
  end

  // Commands arriving while a burst is in flight are dropped here.
  always_comb begin
    seed_d   = seed_q;
    k_d      = k_q;
    tx_start = 1'b0;
    tx_data  = seed_q + {2'b00, k_q};
    unique case (gen_state_q)
      GEN_IDLE:
        if (rx_valid_q) begin
          seed_d = rx_shift_q;
          k_d    = '0;
        end
      GEN_SEND: tx_start = 1'b1;
      GEN_WAIT:
        if (tx_done)
          k_d = k_inc;
      default: k_d = '0;
    endcase
  end

  assign tx_done = (tx_state_q == TX_STOP) &&
                   (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:
        if (tx_start)
          tx_state_d = TX_START;
      TX_START:
        if (tx_cnt_q == BIT_LAST)
          tx_state_d = TX_DATA;
      TX_DATA:
        if (tx_cnt_q == BIT_LAST && tx_bit_q == 3'd7)
          tx_state_d = TX_STOP;
      TX_STOP:
        if (tx_cnt_q == BIT_LAST)
          tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (tx_start)
          tx_shift_d = tx_data;
      end
      TX_START:
        if (tx_cnt_q == BIT_LAST)
          tx_cnt_d = '0;
      TX_DATA:
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      TX_STOP:
        if (tx_cnt_q == BIT_LAST)
          tx_cnt_d = '0;
      default: tx_cnt_d = '0;
    endcase
  end

  // Line level follows the next state so the pin is a clean flop output.
  always_comb begin
    txd_d = 1'b1;
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_wrapper.sv
// Scoreboard bench for uart_wrapper with a shortened bit period.
// Commands push expected reply bytes; a line monitor decodes and compares.
module tb_uart_wrapper;

  localparam int CPB   = 20;
  localparam int HALF  = CPB / 2;
  localparam int RESP  = 32;
  localparam int FRAME = 10 * CPB;

  logic sysclk = 1'b0;
  logic resetn = 1'b0;
  logic uart_txd_in = 1'b1;
  logic uart_rxd_out;

  uart_wrapper #(
    .CLK_FREQ_HZ (192_000),
    .BAUD        (9600),
    .CLKS_PER_BIT(CPB),
    .RESP_LEN    (RESP)
  ) dut (
    .sysclk      (sysclk),
    .resetn      (resetn),
    .uart_txd_in (uart_txd_in),
    .uart_rxd_out(uart_rxd_out)
  );

  always #40 sysclk = ~sysclk;

  typedef struct {
    logic [7:0] b;
    bit         first;
    int         cmd_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   in_frame = 0;
  int   frames_seen = 0;

  initial forever begin
    @(posedge sysclk);
    cyc++;
  end

  task automatic chk(input bit ok, input string name,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // Line monitor: decodes frames and compares against the scoreboard.
  initial begin
    int         pos;
    int         bad;
    int         bit_i;
    int         last_start;
    logic [7:0] dec;
    logic       stopv;
    logic       lvl;
    exp_t       cur;
    bit         cur_valid;
    bit         prev_line;
    pos = 0; bad = 0; last_start = 0; dec = '0; stopv = 1'b1;
    cur_valid = 0; prev_line = 1;
    forever begin
      @(negedge sysclk);
      if (!resetn) begin
        in_frame  = 0;
        prev_line = 1;
        continue;
      end
      if (!in_frame && prev_line && !uart_rxd_out) begin
        in_frame = 1;
        pos = 0; bad = 0; dec = '0; stopv = 1'b0;
        if (exp_q.size() == 0) begin
          cur_valid = 0;
          chk(0, "unexpected_frame", cyc, -1);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1;
          if (cur.first)
            chk(cyc - cur.cmd_cyc >= HALF + 9 * CPB &&
                cyc - cur.cmd_cyc <= HALF + 9 * CPB + 7,
                "first_latency", cyc - cur.cmd_cyc,
                HALF + 9 * CPB + 7);
          else
            chk(cyc - last_start >= FRAME &&
                cyc - last_start <= FRAME + 2,
                "frame_spacing", cyc - last_start, FRAME);
        end
        last_start = cyc;
      end
      if (in_frame) begin
        bit_i = pos / CPB;
        if (bit_i == 0)
          lvl = 1'b0;
        else if (bit_i == 9)
          lvl = 1'b1;
        else
          lvl = cur.b[bit_i - 1];
        if (cur_valid && uart_rxd_out !== lvl)
          bad++;
        if (pos % CPB == HALF) begin
          if (bit_i >= 1 && bit_i <= 8)
            dec[bit_i - 1] = uart_rxd_out;
          if (bit_i == 9)
            stopv = uart_rxd_out;
        end
        pos++;
        if (pos == FRAME) begin
          in_frame = 0;
          frames_seen++;
          if (cur_valid) begin
            chk(dec === cur.b, "frame_byte",
                int'(dec), int'(cur.b));
            chk(stopv === 1'b1 && bad == 0, "frame_shape",
                bad, 0);
          end
        end
      end
      prev_line = uart_rxd_out;
    end
  end

  task automatic cmd(input logic [7:0] n, input bit answered,
                     input int bl, input logic stop_bit);
    @(negedge sysclk);
    if (answered)
      for (int k = 0; k < RESP; k++) begin
        exp_t e;
        e.b       = 8'((int'(n) + k) % 256);
        e.first   = (k == 0);
        e.cmd_cyc = cyc;
        exp_q.push_back(e);
      end
    uart_txd_in = 1'b0;
    repeat (bl) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = n[i];
      repeat (bl) @(negedge sysclk);
    end
    uart_txd_in = stop_bit;
    repeat (bl) @(negedge sysclk);
    uart_txd_in = 1'b1;
  endtask

  task automatic idle(input int n, input string name);
    int lows = 0;
    repeat (n) begin
      @(negedge sysclk);
      if (uart_rxd_out !== 1'b1)
        lows++;
    end
    chk(lows == 0, name, lows, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || in_frame) && t < 40 * FRAME) begin
      @(negedge sysclk);
      t++;
    end
    if (t >= 40 * FRAME)
      chk(0, "drain_timeout", exp_q.size(), 0);
    idle(4 * CPB, "post_burst_idle");
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_seen < target && t < 10 * FRAME) begin
      @(negedge sysclk);
      t++;
    end
    if (t >= 10 * FRAME)
      chk(0, "frame_wait_timeout", frames_seen, target);
  endtask

  initial begin
    int f0;
    int t;
    logic [7:0] n;

    resetn = 1'b0;
    repeat (5) begin
      @(negedge sysclk);
      chk(uart_rxd_out === 1'b1, "reset_line_high",
          int'(uart_rxd_out), 1);
    end
    resetn = 1'b1;
    idle(30 * CPB, "idle_after_reset");

    cmd(8'h00, 1, CPB, 1'b1);
    drain();
    cmd(8'hF0, 1, CPB, 1'b1);
    drain();

    @(negedge sysclk);
    uart_txd_in = 1'b0;
    repeat ($urandom_range(1, HALF - 3)) @(negedge sysclk);
    uart_txd_in = 1'b1;
    idle(20 * CPB, "glitch_no_output");

    cmd(8'h55, 0, CPB, 1'b0);
    idle(20 * CPB, "framing_err_no_output");
    cmd(8'h10, 1, CPB, 1'b1);
    drain();

    f0 = frames_seen;
    cmd(8'h20, 1, CPB, 1'b1);
    wait_frames(f0 + 4);
    cmd(8'h80, 0, CPB, 1'b1);
    drain();

    f0 = frames_seen;
    cmd(8'h33, 1, CPB, 1'b1);
    wait_frames(f0 + 2);
    repeat (HALF + CPB) @(negedge sysclk);
    t = 0;
    while (uart_rxd_out !== 1'b0 && t < FRAME) begin
      @(negedge sysclk);
      t++;
    end
    chk(in_frame && uart_rxd_out === 1'b0, "mid_byte3_low",
        int'(uart_rxd_out), 0);
    resetn = 1'b0;
    #1;
    chk(uart_rxd_out === 1'b1, "async_reset_high",
        int'(uart_rxd_out), 1);
    exp_q.delete();
    repeat (5) begin
      @(negedge sysclk);
      chk(uart_rxd_out === 1'b1, "reset_hold_high",
          int'(uart_rxd_out), 1);
    end
    resetn = 1'b1;
    idle(20 * CPB, "idle_after_midreset");
    cmd(8'h07, 1, CPB, 1'b1);
    drain();

    n = 8'($urandom);
    cmd(n, 1, CPB + 1, 1'b1);
    drain();
    n = 8'($urandom);
    cmd(n, 1, CPB - 1, 1'b1);
    drain();

    repeat ($urandom_range(5, 50)) @(negedge sysclk);
    n = 8'($urandom);
    cmd(n, 1, CPB, 1'b1);
    drain();

    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
